tdm_demux_1x4: RTL and testbench

Four-channel time-division demultiplexer: the receive end of the 4:1 channel multiplexer. It takes one DATA_W-bit slot stream, locks onto a frame-sync marker, and distributes consecutive slots to four registered channel outputs, each with a one-cycle valid strobe. It sits after the link that carries the muxed stream and before per-channel consumers. Frame-alignment errors are flagged and the block re-locks on its own.

---
 rtl/tdm_demux_pkg.sv | 14 +
 rtl/tdm_sync_fsm.sv | 83 ++++++++
 rtl/tdm_demux_1x4.sv | 66 ++++++
 tb/tb_tdm_demux_1x4.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux_pkg.sv
// Shared types and constants for the 1:4 TDM demultiplexer.
package tdm_demux_pkg;

   localparam int         NUM_CH     = 4;
   localparam logic [7:0] ERRCNT_MAX = 8'd255;

   typedef logic [1:0] slot_t;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

endpackage

// File: rtl/tdm_sync_fsm.sv
// Frame-alignment FSM: tracks the slot position and decides which channel each beat writes.
module tdm_sync_fsm
   import tdm_demux_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   din_valid,
   input  logic   frame_sync,
   output logic   wr_en,
   output slot_t  wr_slot,
   output logic   frame_done,
   output logic   sync_err,
   output state_t state
);

   slot_t  slot;
   slot_t  slot_nxt;
   state_t state_nxt;
   logic   done_nxt;
   logic   err_nxt;

   // Write decision is combinational so the channel register captures the same beat.
   always_comb begin
      wr_en     = 1'b0;
      wr_slot   = slot;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      state_nxt = state;
      slot_nxt  = slot;
      if (din_valid) begin
         case (state)
            HUNT: begin
               if (frame_sync) begin
                  wr_en     = 1'b1;
                  wr_slot   = 2'd0;
                  slot_nxt  = 2'd1;
                  state_nxt = LOCKED;
               end
            end
            LOCKED: begin
               if (slot == 2'd0) begin
                  if (frame_sync) begin
                     wr_en    = 1'b1;
                     wr_slot  = 2'd0;
                     slot_nxt = 2'd1;
                  end else begin
                     err_nxt   = 1'b1;
                     slot_nxt  = 2'd0;
                     state_nxt = HUNT;
                  end
               end else if (frame_sync) begin
                  // Early sync: abandon the partial frame and restart at slot 0.
                  err_nxt  = 1'b1;
                  wr_en    = 1'b1;
                  wr_slot  = 2'd0;
                  slot_nxt = 2'd1;
               end else begin
                  wr_en    = 1'b1;
                  wr_slot  = slot;
                  done_nxt = (slot == 2'd3);
                  slot_nxt = slot_t'(slot + 2'd1);
               end
            end
            default: state_nxt = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= HUNT;
         slot       <= 2'd0;
         frame_done <= 1'b0;
         sync_err   <= 1'b0;
      end else begin
         state      <= state_nxt;
         slot       <= slot_nxt;
         frame_done <= done_nxt;
         sync_err   <= err_nxt;
      end
   end

endmodule

// File: rtl/tdm_demux_1x4.sv
// 1:4 TDM demultiplexer with frame-sync lock; channel registers live here.
// Optional saturating error counter enabled by TDM_DEMUX_ERRCNT_EN.
module tdm_demux_1x4
   import tdm_demux_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [DATA_W-1:0]        din,
   input  logic                     din_valid,
   input  logic                     frame_sync,
   output logic [NUM_CH*DATA_W-1:0] ch_data,
   output logic [NUM_CH-1:0]        ch_valid,
   output logic                     frame_done,
   output logic                     locked,
   output logic                     sync_err
`ifdef TDM_DEMUX_ERRCNT_EN
   ,
   output logic [7:0]               err_cnt
`endif
);

   logic   wr_en;
   slot_t  wr_slot;
   state_t fsm_state;

   tdm_sync_fsm u_fsm (
      .clk        (clk),
      .rst_n      (rst_n),
      .din_valid  (din_valid),
      .frame_sync (frame_sync),
      .wr_en      (wr_en),
      .wr_slot    (wr_slot),
      .frame_done (frame_done),
      .sync_err   (sync_err),
      .state      (fsm_state)
   );

   assign locked = (fsm_state == LOCKED);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch_data  <= '0;
         ch_valid <= '0;
      end else begin
         ch_valid <= '0;
         if (wr_en) begin
            ch_data[wr_slot*DATA_W +: DATA_W] <= din;
            ch_valid[wr_slot]                 <= 1'b1;
         end
      end
   end

`ifdef TDM_DEMUX_ERRCNT_EN
   // Counts registered error pulses, so it trails sync_err by one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= 8'd0;
      end else if (sync_err && (err_cnt != ERRCNT_MAX)) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_tdm_demux_1x4.sv
// Scoreboard bench for tdm_demux_1x4; err_cnt checks compile in with TDM_DEMUX_ERRCNT_EN.
module tb_tdm_demux_1x4;

   localparam int DATA_W = 8;
   localparam int W      = 4*DATA_W + 4 + 3;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [DATA_W-1:0]   din = '0;
   logic                din_valid = 1'b0;
   logic                frame_sync = 1'b0;
   logic [4*DATA_W-1:0] ch_data;
   logic [3:0]          ch_valid;
   logic                frame_done;
   logic                locked;
   logic                sync_err;
`ifdef TDM_DEMUX_ERRCNT_EN
   logic [7:0]          err_cnt;
`endif

   tdm_demux_1x4 #(.DATA_W(DATA_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .din_valid  (din_valid),
      .frame_sync (frame_sync),
      .ch_data    (ch_data),
      .ch_valid   (ch_valid),
      .frame_done (frame_done),
      .locked     (locked),
      .sync_err   (sync_err)
`ifdef TDM_DEMUX_ERRCNT_EN
      ,
      .err_cnt    (err_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] mon_e;

   // Reference model state
   logic        m_state;
   logic [1:0]  m_slot;
   logic [7:0]  m_ch[4];
   int          m_err;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 1'b0;
      m_slot  = 2'd0;
      for (int k = 0; k < 4; k++) m_ch[k] = 8'h00;
      m_err   = 0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ch_data"},    ch_data,    '0);
      check({tag, "_ch_valid"},   ch_valid,   '0);
      check({tag, "_frame_done"}, frame_done, '0);
      check({tag, "_sync_err"},   sync_err,   '0);
      check({tag, "_locked"},     locked,     '0);
   endtask

   task automatic beat(input logic v, input logic fs, input logic [7:0] d);
      logic [3:0] vld;
      logic       done;
      logic       err;
      int         wk;
      vld  = 4'b0000;
      done = 1'b0;
      err  = 1'b0;
      wk   = -1;
      @(negedge clk);
      #1;
      din_valid  = v;
      frame_sync = v ? fs : 1'($urandom_range(0, 1));
      din        = v ? d : 8'($urandom);
      if (v) begin
         if (m_state == 1'b0) begin
            if (fs) begin
               wk = 0; m_slot = 2'd1; m_state = 1'b1;
            end
         end else if (m_slot == 2'd0) begin
            if (fs) begin
               wk = 0; m_slot = 2'd1;
            end else begin
               err = 1'b1; m_state = 1'b0;
            end
         end else if (fs) begin
            err = 1'b1; wk = 0; m_slot = 2'd1;
         end else begin
            wk     = int'(m_slot);
            done   = (m_slot == 2'd3);
            m_slot = (m_slot == 2'd3) ? 2'd0 : m_slot + 2'd1;
         end
      end
      if (wk >= 0) begin
         m_ch[wk] = d;
         vld[wk]  = 1'b1;
      end
      if (err && m_err < 255) m_err++;
      exp_q.push_back({m_ch[3], m_ch[2], m_ch[1], m_ch[0], vld, done, err, m_state});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 8'h00);
   endtask

   task automatic gap();
      idle($urandom_range(1, 3));
   endtask

   always @(negedge clk) begin
      if (rst_n && exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check("ch_data",    ch_data,    mon_e[W-1:7]);
         check("ch_valid",   ch_valid,   mon_e[6:3]);
         check("frame_done", frame_done, mon_e[2]);
         check("sync_err",   sync_err,   mon_e[1]);
         check("locked",     locked,     mon_e[0]);
      end
   end

   initial begin
      model_reset();
      // Reset held with random traffic
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         din_valid  = 1'($urandom_range(0, 1));
         frame_sync = 1'($urandom_range(0, 1));
         din        = 8'($urandom);
         #1;
         check_all_zero("rst_hold");
      end
      @(negedge clk);
      din_valid = 1'b0;
      rst_n     = 1'b1;

      // Acquire
      for (int i = 0; i < 3; i++) beat(1'b1, 1'b0, 8'hAA);
      beat(1'b1, 1'b1, 8'h11);
      beat(1'b1, 1'b0, 8'h22);
      beat(1'b1, 1'b0, 8'h33);
      beat(1'b1, 1'b0, 8'h44);
      idle(2);
      check("acquire_ch_data", ch_data, 32'h44332211);

      // Gaps and wrap
      beat(1'b1, 1'b1, 8'h11); gap();
      beat(1'b1, 1'b0, 8'h22); gap();
      beat(1'b1, 1'b0, 8'h33); gap();
      beat(1'b1, 1'b0, 8'h44); gap();
      beat(1'b1, 1'b1, 8'h55); gap();
      beat(1'b1, 1'b0, 8'h66); gap();
      beat(1'b1, 1'b0, 8'h77); gap();
      beat(1'b1, 1'b0, 8'h88);
      idle(2);
      check("wrap_ch_data", ch_data, 32'h88776655);

      // Early sync
      beat(1'b1, 1'b1, 8'h01);
      beat(1'b1, 1'b0, 8'h02);
      beat(1'b1, 1'b1, 8'h09);
      beat(1'b1, 1'b0, 8'h0A);
      beat(1'b1, 1'b0, 8'h0B);
      beat(1'b1, 1'b0, 8'h0C);

      // Missing sync, then re-lock
      beat(1'b1, 1'b0, 8'hFF);
      beat(1'b1, 1'b0, 8'hEE);
      beat(1'b1, 1'b1, 8'h5A);
      beat(1'b1, 1'b0, 8'h5B);
      idle(2);
`ifdef TDM_DEMUX_ERRCNT_EN
      check("err_cnt_early", err_cnt, 8'(m_err));
`endif

      // Random traffic
      for (int i = 0; i < 80; i++)
         beat($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 8'($urandom));
      idle(2);

      // Asynchronous reset mid-frame
      beat(1'b1, 1'b1, 8'hC1);
      beat(1'b1, 1'b0, 8'hC2);
      @(posedge clk);
      #2;
      rst_n     = 1'b0;
      din_valid = 1'b0;
      #1;
      check_all_zero("rst_async");
      exp_q.delete();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      beat(1'b1, 1'b0, 8'hC3);
      beat(1'b1, 1'b1, 8'hD0);
      beat(1'b1, 1'b0, 8'hD1);
      idle(2);

`ifdef TDM_DEMUX_ERRCNT_EN
      for (int i = 0; i < 300; i++) begin
         beat(1'b1, 1'b1, 8'(i));
         beat(1'b1, 1'b0, 8'h01);
         beat(1'b1, 1'b0, 8'h02);
         beat(1'b1, 1'b0, 8'h03);
         beat(1'b1, 1'b0, 8'hFF);
      end
      idle(2);
      check("err_cnt_model", err_cnt, 8'(m_err));
      check("err_cnt_sat", err_cnt, 8'd255);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("err_cnt_reset", err_cnt, 8'd0);
      exp_q.delete();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
`endif

      idle(2);
      @(negedge clk);
      #1;
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
